// File: rtl/lc3b_mem_if.sv
// lc3b_mem_if
//   Memory interface stage downstream of the LC-3b control unit. Owns MAR and
//   MDR, runs word/byte reads and writes against a synchronous SRAM with a
//   fixed latency of WAIT_CYCLES, and returns a one-cycle ready pulse (r).
//
// Ports:
//   clk_50, rst_n          clock (rising edge), synchronous active-low reset
//   bus                    datapath bus; source for MAR and for MDR bus loads
//   ldmar, ldmdr           register load strobes
//   mio_en, rw, datasize   access request, 0=read/1=write, 0=byte/1=word
//   r                      access complete, one-cycle pulse
//   mdr_out                MDR as seen by GateMDR (byte values sign-extended)
//   mar_out                current MAR
//   unaligned              sticky: a word access started with MAR[0]=1
//   mem_addr, mem_wdata    SRAM word address and write data (latched at start)
//   mem_we, mem_be         SRAM write enable and byte enables
//   mem_rdata              SRAM read data, valid in the last ACCESS cycle
module lc3b_mem_if #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned AW          = 16
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic [15:0]   bus,
    input  logic          ldmar,
    input  logic          ldmdr,
    input  logic          mio_en,
    input  logic          rw,
    input  logic          datasize,
    output logic          r,
    output logic [15:0]   mdr_out,
    output logic [15:0]   mar_out,
    output logic          unaligned,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    input  logic [15:0]   mem_rdata
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

    state_t        state, state_nxt;
    logic          start;
    logic [15:0]   mar, mdr;
    logic [CW-1:0] cnt;
    logic [7:0]    byte_sel;

    always_ff @(posedge clk_50) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (mio_en && (rw || ldmdr)) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = HOLD;
            // One dead cycle so a lagging registered request cannot relaunch.
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            mar       <= '0;
            mdr       <= '0;
            r         <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unaligned <= 1'b0;
            cnt       <= '0;
        end else begin
            r <= 1'b0;
            if (ldmar) mar <= bus;
            case (state)
                IDLE: begin
                    if (ldmdr && !mio_en)
                        mdr <= datasize ? bus : {bus[7:0], bus[7:0]};
                    if (start) begin
                        // Uses the pre-edge MAR even if ldmar fires on this edge.
                        mem_addr  <= AW'({mar[15:1], 1'b0});
                        mem_wdata <= mdr;
                        mem_be    <= datasize ? 2'b11 : (mar[0] ? 2'b10 : 2'b01);
                        mem_we    <= rw;
                        cnt       <= CNT_INIT;
                        if (datasize && mar[0]) unaligned <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_we <= 1'b0;
                        if (!mem_we) mdr <= mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    r      <= 1'b1;
                    mem_be <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = mar[0] ? mdr[15:8] : mdr[7:0];
        mdr_out  = datasize ? mdr : {{8{byte_sel[7]}}, byte_sel};
    end

    assign mar_out = mar;

endmodule
